// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide sequencer.
//   - muldiv_op_e   : Funct3 encodings of the M-extension operations
//   - ST_*          : sequencer FSM state codes
//   - MODE_*        : datapath mode select for the single-iteration step
//   - FUNCT7_MULDIV : Funct7 value that routes an R-type to this unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational datapath for one iteration of the sequencer.
// Ports:
//   acc      in  2*DATA_WIDTH  current accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, dividend bits / quotient bits}
//   operand  in  DATA_WIDTH    multiplicand (multiply) or divisor (divide)
//   mode     in  1             MODE_MUL or MODE_DIV
//   acc_next out 2*DATA_WIDTH  accumulator after one iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    mode,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  localparam int W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] trial;

  always_comb begin
    // Shift-add: the carry out of the add becomes the new MSB after the right shift.
    sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
    // Restoring divide: trial subtract on the remainder shifted left by one.
    trial = acc[2*W-1:W-1] - {1'b0, operand};
    if (mode == MODE_MUL) begin
      acc_next = {sum, acc[W-1:1]};
    end else if (!trial[W]) begin
      acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
    end else begin
      acc_next = {acc[2*W-2:W-1], acc[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit (one bit per cycle).
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       request, accepted only in IDLE while done is low
//   flush       aborts any operation in flight, no done follows
//   Funct3      M-extension operation select
//   SrcA, SrcB  rs1 / rs2 operands
//   busy        stall request, high from acceptance until done rises
//   done        one-cycle pulse, Result valid
//   Result      registered result, only written in FIX
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W = DATA_WIDTH;

  logic [1:0]           state;
  logic [2:0]           op;
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       acc_next;
  logic [W-1:0]         operand;
  logic [CNT_WIDTH-1:0] count;
  logic                 res_neg;
  logic                 rem_neg;
  logic                 special;

  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         div_op, div_zero, div_ovf, accept;

  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem, fixed_word;

  muldiv_step #(.DATA_WIDTH(W)) u_step (
    .acc      (acc),
    .operand  (operand),
    .mode     (op[2]),
    .acc_next (acc_next)
  );

  always_comb begin
    div_op   = Funct3[2];
    a_signed = (Funct3 == OP_MUL) || (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
               (Funct3 == OP_DIV) || (Funct3 == OP_REM);
    b_signed = (Funct3 == OP_MUL) || (Funct3 == OP_MULH) ||
               (Funct3 == OP_DIV) || (Funct3 == OP_REM);
    a_neg    = a_signed & SrcA[W-1];
    b_neg    = b_signed & SrcB[W-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    div_zero = div_op && (SrcB == '0);
    div_ovf  = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
               (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    // The done cycle still carries the previous request on start; ignore it.
    accept   = (state == ST_IDLE) && start && !flush && !done;
  end

  always_comb begin
    prod = res_neg ? -acc : acc;
    // Special-case results are loaded already final, so they skip sign fixing.
    quo  = (res_neg && !special) ? -acc[W-1:0]   : acc[W-1:0];
    rem  = (rem_neg && !special) ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      OP_MUL:                       fixed_word = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixed_word = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              fixed_word = quo;
      default:                      fixed_word = rem;
    endcase
  end

  // done and busy are registered, so done rises one edge after entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op      <= '0;
      acc     <= '0;
      operand <= '0;
      count   <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      special <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Result  <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              op      <= Funct3;
              res_neg <= a_neg ^ b_neg;
              rem_neg <= a_neg;
              count   <= '0;
              busy    <= 1'b1;
              if (div_zero) begin
                acc     <= {SrcA, {W{1'b1}}};
                special <= 1'b1;
                state   <= ST_FIX;
              end else if (div_ovf) begin
                acc     <= {{W{1'b0}}, SrcA};
                special <= 1'b1;
                state   <= ST_FIX;
              end else begin
                special <= 1'b0;
                state   <= ST_CALC;
                if (div_op) begin
                  acc     <= {{W{1'b0}}, a_mag};
                  operand <= b_mag;
                end else begin
                  acc     <= {{W{1'b0}}, b_mag};
                  operand <= a_mag;
                end
              end
            end
          end
          ST_CALC: begin
            acc   <= acc_next;
            count <= count + CNT_WIDTH'(1);
            if (count == CNT_WIDTH'(W-1)) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: begin
            Result <= fixed_word;
            state  <= ST_DONE;
          end
          default: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer. Stimulus pushes
// expected results; a negedge monitor pops and compares whenever done is high.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           t0_q[$];
  logic [W-1:0] last_result = '0;
  logic [W-1:0] mon_exp;
  int           mon_lat;
  int           mon_t0;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t dir[$];

  muldiv_sequencer #(.DATA_WIDTH(W)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ub = longint'({32'b0, b});
    case (f3)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    bit is_div, ovf;
    is_div = (f3 == OP_DIV) || (f3 == OP_DIVU) || (f3 == OP_REM) || (f3 == OP_REMU);
    ovf    = ((f3 == OP_DIV) || (f3 == OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    return (is_div && (b == 0 || ovf)) ? 2 : W + 2;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=done_high expected=no_done Result=0x%0h time=%0t",
                 Result, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_lat = lat_q.pop_front();
        mon_t0  = t0_q.pop_front();
        checkOutput("result", 64'(Result), 64'(mon_exp));
        checkOutput("latency", 64'(cyc - mon_t0), 64'(mon_lat));
        last_result = mon_exp;
      end
    end
  end

  // Caller is at a negedge; returns one negedge after the accepting edge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit track, input logic [W-1:0] exp, input int lat);
    int guard = 0;
    while ((busy || done) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("idle_wait_timeout", 64'(busy), 64'(0));
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      t0_q.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic waitForDone(input int seen, input int exp_busy, input bit poke_start);
    int bc    = seen;
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
      if (busy) bc++;
    end
    checkOutput("done_seen", 64'(found), 64'(1));
    checkOutput("busy_cycles", 64'(bc), 64'(exp_busy));
    if (poke_start) begin
      Funct3 = OP_MULHU;
      SrcA   = '1;
      SrcB   = '1;
      start  = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_single_pulse", 64'(done), 64'(0));
    if (poke_start) checkOutput("start_in_done_ignored", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic [2:0]   f3;
    logic [W-1:0] a, b;

    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    Funct3 = '0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_result", 64'(Result), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    dir.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    dir.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34});
    dir.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    dir.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    dir.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
    dir.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
    dir.push_back('{OP_DIVU,   32'd100,        32'd7,         32'd14,        34});
    dir.push_back('{OP_REMU,   32'd100,        32'd7,         32'd2,         34});
    dir.push_back('{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2});
    dir.push_back('{OP_REM,    32'd5,          32'd0,         32'd5,         2});
    dir.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2});
    dir.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2});

    foreach (dir[i]) begin
      applyStimulus(dir[i].f3, dir[i].a, dir[i].b, 1'b1, dir[i].exp, dir[i].lat);
      waitForDone(1, dir[i].lat, i == 0);
    end

    // Second start at edge 5 with different operands must be ignored.
    applyStimulus(OP_MUL, 32'd123, 32'd456, 1'b1, 32'd56088, 34);
    repeat (4) @(negedge clk);
    Funct3 = OP_DIVU;
    SrcA   = 32'd999;
    SrcB   = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitForDone(6, 34, 1'b0);

    // Flush at edge 10, then a new start in the following cycle.
    applyStimulus(OP_DIVU, 32'd5000, 32'd3, 1'b0, '0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", 64'(busy), 64'(0));
    checkOutput("flush_result_hold", 64'(Result), 64'(last_result));
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 1'b1, 32'd142, 34);
    waitForDone(1, 34, 1'b0);

    // flush together with start in IDLE: nothing accepted.
    flush  = 1'b1;
    start  = 1'b1;
    Funct3 = OP_MUL;
    SrcA   = 32'd9;
    SrcB   = 32'd9;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_start_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    checkOutput("flush_start_result", 64'(Result), 64'(last_result));

    // Asynchronous reset in the middle of CALC.
    applyStimulus(OP_MUL, 32'd5, 32'd6, 1'b0, '0, 0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 64'(0));
    checkOutput("async_reset_done", 64'(done), 64'(0));
    checkOutput("async_reset_result", 64'(Result), 64'(0));
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("post_reset_result", 64'(Result), 64'(0));
    checkOutput("post_reset_busy", 64'(busy), 64'(0));

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      applyStimulus(f3, a, b, 1'b1, ref_model(f3, a, b), ref_latency(f3, a, b));
      waitForDone(1, ref_latency(f3, a, b), 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
